div_unit: RTL and testbench

- Parametrised multi-cycle radix-2 restoring divider for the execute stage. Handles DIV/DIVU and their wider-datapath variants.
- Execute issues operands and holds start_i. The block returns {remainder, quotient} for the HI/LO write path through the ex_mem/mem_wb chain.
- Execute stalls the pipeline while busy_o=1.
- Supports signed/unsigned mode, divide-by-zero detection and annulment by a pipeline flush.

---
 rtl/div_unit.sv | 150 +++++++++++++++
 tb/tb_div_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider (signed/unsigned) for the execute stage.
// Latency: WIDTH+1 edges from the sampling edge to ready for a normal divide, 1 edge for divide-by-zero.
// Backpressure: the result and ready are held while start stays high; dropping start releases them.
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   start_i                   request, held by execute until the result is consumed
//   annul_i                   flush; aborts an in-progress iterative divide only
//   signed_div_i              1 = signed, 0 = unsigned; sampled with start_i
//   opdata1_i / opdata2_i     dividend / divisor; sampled with start_i
//   result_o                  {remainder, quotient}
//   ready_o / busy_o          result valid / division in progress
//   div_zero_o                divisor was zero (valid with ready_o)
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // Working register: upper WIDTH+1 bits hold the partial remainder plus the
  // next dividend bit, quotient bits are shifted in at the bottom.
  logic [2*WIDTH:0] work;
  logic [WIDTH-1:0] dvsr;
  logic             sgn_mode;
  logic             sign1;
  logic             sign2;

  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;
  logic             trial_neg;
  logic [WIDTH-1:0] trial_diff;
  logic [WIDTH-1:0] quo_mag;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;

  assign op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // The upper field is always below 2*divisor, so the difference fits in
  // WIDTH+1 bits two's complement and its MSB is a valid borrow flag.
  assign {trial_neg, trial_diff} = work[2*WIDTH:WIDTH] - {1'b0, dvsr};

  assign quo_mag = work[WIDTH-1:0];
  assign rem_mag = work[2*WIDTH:WIDTH+1];
  // Most-negative / -1 simply wraps back to most-negative; no trap.
  assign quo_fin = (sgn_mode && (sign1 ^ sign2)) ? -quo_mag : quo_mag;
  assign rem_fin = (sgn_mode && sign1) ? -rem_mag : rem_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      work       <= '0;
      dvsr       <= '0;
      sgn_mode   <= 1'b0;
      sign1      <= 1'b0;
      sign2      <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
      busy_o     <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          result_o   <= '0;
          ready_o    <= 1'b0;
          div_zero_o <= 1'b0;
          if (start_i && !annul_i) begin
            busy_o <= 1'b1;
            if (opdata2_i == '0) begin
              state <= S_BYZERO;
            end else begin
              state    <= S_ON;
              sgn_mode <= signed_div_i;
              sign1    <= opdata1_i[WIDTH-1];
              sign2    <= opdata2_i[WIDTH-1];
              dvsr     <= op2_mag;
              work     <= {{WIDTH{1'b0}}, op1_mag, 1'b0};
              cnt      <= '0;
            end
          end
        end

        // Flush is deliberately ignored here: the zero-divide completes and
        // execute discards it by dropping start_i.
        S_BYZERO: begin
          state      <= S_END;
          busy_o     <= 1'b0;
          result_o   <= '0;
          div_zero_o <= 1'b1;
          ready_o    <= 1'b1;
        end

        S_ON: begin
          if (annul_i) begin
            state   <= S_IDLE;
            busy_o  <= 1'b0;
            ready_o <= 1'b0;
          end else if (cnt != CNT_W'(WIDTH)) begin
            if (trial_neg) begin
              work <= {work[2*WIDTH-1:0], 1'b0};
            end else begin
              work <= {trial_diff, work[WIDTH-1:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
          end else begin
            state      <= S_END;
            busy_o     <= 1'b0;
            result_o   <= {rem_fin, quo_fin};
            ready_o    <= 1'b1;
            div_zero_o <= 1'b0;
          end
        end

        S_END: begin
          if (!start_i) begin
            state      <= S_IDLE;
            result_o   <= '0;
            ready_o    <= 1'b0;
            div_zero_o <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed table-driven bench for div_unit at WIDTH=32.
// Latency: each vector checks the edge count from sampling to ready.
// Backpressure: each vector holds start through one extra edge, then drops it.
module tb_div_unit;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           annul_i;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;
  logic           div_zero_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic       sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .div_zero_o   (div_zero_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input string nm, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] q,
                         input logic [W-1:0] r, input logic dz);
    int n;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();  // sampling edge E0
    chk({nm, " busy_after_E0"}, 64'(busy_o), 64'd1);
    chk({nm, " ready_after_E0"}, 64'(ready_o), 64'd0);
    // Operands must be ignored once sampled.
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sgn;
    n = 0;
    while (!ready_o && n < 100) begin
      tick();
      n++;
    end
    chk({nm, " latency"}, 64'(n), dz ? 64'd1 : 64'(W + 1));
    chk({nm, " result"}, result_o, {r, q});
    chk({nm, " div_zero"}, 64'(div_zero_o), 64'(dz));
    chk({nm, " busy_at_ready"}, 64'(busy_o), 64'd0);
    tick();
    chk({nm, " hold_ready"}, 64'(ready_o), 64'd1);
    chk({nm, " hold_result"}, result_o, {r, q});
    start_i = 1'b0;
    tick();
    chk({nm, " drop_ready"}, 64'(ready_o), 64'd0);
    chk({nm, " drop_result"}, result_o, 64'd0);
    chk({nm, " drop_dz"}, 64'(div_zero_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_rdy;

    vecs[0]  = '{"u100_7",      1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{"s_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{"u_m7_2",      1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};
    vecs[3]  = '{"s_ovf",       1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[4]  = '{"s_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[5]  = '{"u_zero",      1'b0, 32'h1234,       32'd0,          32'd0,          32'd0,          1'b1};
    vecs[6]  = '{"s_m100_m7",   1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[7]  = '{"u_msb_msb",   1'b0, 32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0};
    vecs[8]  = '{"s_min_2",     1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0};
    vecs[9]  = '{"u_ff_ff",     1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    vecs[10] = '{"s_zero",      1'b1, 32'h80000000,   32'd0,          32'd0,          32'd0,          1'b1};

    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    #2;
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    chk("reset dz", 64'(div_zero_o), 64'd0);
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
    end

    // Flush at step 10: no result ever appears.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    tick();
    chk("annul busy_E0", 64'(busy_o), 64'd1);
    repeat (10) tick();
    chk("annul busy_step10", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    chk("annul busy_after", 64'(busy_o), 64'd0);
    chk("annul ready_after", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    n_rdy = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready_o) n_rdy++;
    end
    chk("annul no_ready", 64'(n_rdy), 64'd0);

    // Flush together with start in IDLE: the request is not accepted.
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    repeat (3) tick();
    chk("annul_idle busy", 64'(busy_o), 64'd0);
    chk("annul_idle ready", 64'(ready_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();
    run_div("u9_3_after_annul", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Flush is ignored for a zero-divide.
    signed_div_i = 1'b0;
    opdata1_i    = 32'h1234;
    opdata2_i    = 32'd0;
    start_i      = 1'b1;
    tick();
    chk("zero_annul busy", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    tick();
    chk("zero_annul ready", 64'(ready_o), 64'd1);
    chk("zero_annul dz", 64'(div_zero_o), 64'd1);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    chk("zero_annul drop", 64'(ready_o), 64'd0);

    // Asynchronous reset between edges while iterating.
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    tick();
    repeat (5) tick();
    chk("arst busy_before", 64'(busy_o), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst busy", 64'(busy_o), 64'd0);
    chk("arst ready", 64'(ready_o), 64'd0);
    chk("arst result", result_o, 64'd0);
    chk("arst dz", 64'(div_zero_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_div("u_ffffffff_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
